// File: rtl/alu_ctrl_seq_pkg.sv
// Shared definitions for the ALU control sequencer: instruction layout,
// opcodes, cond encodings, FSM states and the flag/instruction payloads.
package alu_ctrl_seq_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned FMT_ADR_W = 3;
  localparam int unsigned COND_W    = 3;

  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned W_LSB    = 9;
  localparam int unsigned R_LSB    = 6;
  localparam int unsigned S_LSB    = 3;
  localparam int unsigned COND_LSB = 0;

  // 0000-1100 are passed straight to the ALU; the top three are sequencer ops
  typedef enum logic [OPC_W-1:0] {
    ALU_PASS_S = 4'b0000,
    ALU_PASS_R = 4'b0001,
    ALU_INC    = 4'b0010,
    ALU_DEC    = 4'b0011,
    ALU_ADD    = 4'b0100,
    ALU_SUB    = 4'b0101,
    ALU_AND    = 4'b0110,
    ALU_OR     = 4'b0111,
    ALU_XOR    = 4'b1000,
    ALU_NOT    = 4'b1001,
    ALU_SHL    = 4'b1010,
    ALU_SHR    = 4'b1011,
    ALU_NEG    = 4'b1100,
    OP_CMP     = 4'b1101,
    OP_CLRF    = 4'b1110,
    OP_HALT    = 4'b1111
  } opc_e;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_N      = 3'b011,
    COND_C      = 3'b100,
    COND_NC     = 3'b101,
    COND_NEVER0 = 3'b110,
    COND_NEVER1 = 3'b111
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition check: decides whether an instruction with the
// given cond field is taken under the current latched flags.
module alu_cond_eval
  import alu_ctrl_seq_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  cond_e  cond,
  input  flags_t flags,
  output logic   take
);

  always_comb begin
    take = 1'b0;
    if (!COND_EN) begin
      take = 1'b1;
    end else begin
      case (cond)
        COND_ALWAYS: take = 1'b1;
        COND_Z:      take = flags.z;
        COND_NZ:     take = !flags.z;
        COND_N:      take = flags.n;
        COND_C:      take = flags.c;
        COND_NC:     take = !flags.c;
        default:     take = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle ALU control sequencer: accepts one instruction at a time,
// gates it on the latched flags, drives the ALU/regfile for one EXEC cycle.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int unsigned ADR_W   = 3,
  parameter int unsigned COND_EN = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Instr_Valid,
  output logic               Instr_Ready,
  output logic [OPC_W-1:0]   Alu_Op,
  output logic [ADR_W-1:0]   R_Adr,
  output logic [ADR_W-1:0]   S_Adr,
  output logic [ADR_W-1:0]   W_Adr,
  output logic               W_En,
  input  logic               N,
  input  logic               Z,
  input  logic               C,
  output logic               N_Q,
  output logic               Z_Q,
  output logic               C_Q,
  output logic               Done,
  output logic               Halted
);

  if (ADR_W != FMT_ADR_W) begin : g_adr_w_check
    $error("alu_ctrl_seq: ADR_W must match the 3-bit register fields of the instruction");
  end

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  flags_t               flags_q, flags_d;
  logic                 ready_q, ready_d;
  opc_e                 alu_op_q, alu_op_d;
  logic [ADR_W-1:0]     r_adr_q, r_adr_d, s_adr_q, s_adr_d, w_adr_q, w_adr_d;
  logic                 w_en_q, w_en_d, done_q, done_d, halted_q, halted_d;

  opc_e                 opc;
  cond_e                cond;
  logic                 take;

  assign opc  = opc_e'(instr_q[OPC_LSB +: OPC_W]);
  assign cond = cond_e'(instr_q[COND_LSB +: COND_W]);

  alu_cond_eval #(
    .COND_EN (COND_EN != 0)
  ) u_cond_eval (
    .cond  (cond),
    .flags (flags_q),
    .take  (take)
  );

  // Next state plus the output values that the next state will present
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    flags_d  = flags_q;
    ready_d  = 1'b0;
    alu_op_d = ALU_PASS_S;
    r_adr_d  = '0;
    s_adr_d  = '0;
    w_adr_d  = '0;
    w_en_d   = 1'b0;
    done_d   = 1'b0;
    halted_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Instr_Valid) begin
          instr_d = Instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!take) begin
          state_d = ST_RETIRE;
        end else if (opc == OP_HALT) begin
          state_d = ST_HALT;
        end else if (opc == OP_CLRF) begin
          flags_d = '0;
          state_d = ST_RETIRE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        flags_d = '{n: N, z: Z, c: C};
        state_d = ST_RETIRE;
      end
      ST_RETIRE: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE);
    halted_d = (state_d == ST_HALT);
    done_d   = (state_d == ST_RETIRE) || (state_d == ST_HALT && state_q != ST_HALT);

    // Datapath controls are only ever live for the single EXEC cycle
    if (state_d == ST_EXEC) begin
      alu_op_d = (opc == OP_CMP) ? ALU_SUB : opc;
      r_adr_d  = ADR_W'(instr_q[R_LSB +: FMT_ADR_W]);
      s_adr_d  = ADR_W'(instr_q[S_LSB +: FMT_ADR_W]);
      w_adr_d  = ADR_W'(instr_q[W_LSB +: FMT_ADR_W]);
      w_en_d   = (opc != OP_CMP);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      flags_q  <= '0;
      ready_q  <= 1'b1;
      alu_op_q <= ALU_PASS_S;
      r_adr_q  <= '0;
      s_adr_q  <= '0;
      w_adr_q  <= '0;
      w_en_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
      alu_op_q <= alu_op_d;
      r_adr_q  <= r_adr_d;
      s_adr_q  <= s_adr_d;
      w_adr_q  <= w_adr_d;
      w_en_q   <= w_en_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign Instr_Ready = ready_q;
  assign Alu_Op      = alu_op_q;
  assign R_Adr       = r_adr_q;
  assign S_Adr       = s_adr_q;
  assign W_Adr       = w_adr_q;
  assign W_En        = w_en_q;
  assign N_Q         = flags_q.n;
  assign Z_Q         = flags_q.z;
  assign C_Q         = flags_q.c;
  assign Done        = done_q;
  assign Halted      = halted_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a per-instruction timeline model checked every
// cycle, plus directed vectors with hand-computed latencies and flags.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] Instr = '0;
  logic        Instr_Valid = 1'b0;
  logic        Instr_Ready;
  logic [3:0]  Alu_Op;
  logic [2:0]  R_Adr, S_Adr, W_Adr;
  logic        W_En;
  logic        N = 1'b0, Z = 1'b0, C = 1'b0;
  logic        N_Q, Z_Q, C_Q;
  logic        Done, Halted;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_ctrl_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .Alu_Op      (Alu_Op),
    .R_Adr       (R_Adr),
    .S_Adr       (S_Adr),
    .W_Adr       (W_Adr),
    .W_En        (W_En),
    .N           (N),
    .Z           (Z),
    .C           (C),
    .N_Q         (N_Q),
    .Z_Q         (Z_Q),
    .C_Q         (C_Q),
    .Done        (Done),
    .Halted      (Halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: expected per-cycle outputs as a timeline ----------------
  typedef struct {
    bit       ready;
    bit [3:0] alu_op;
    bit [2:0] r, s, w;
    bit       w_en, done, halted;
    bit       latch, clr;
  } exp_t;

  exp_t     sched[$];
  exp_t     cur;
  bit [2:0] m_flags;
  bit       m_halted;
  bit       chk_en = 1'b0;

  function automatic exp_t idle_rec();
    exp_t e = '{default: 0};
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic exp_t halt_rec();
    exp_t e = '{default: 0};
    e.halted = 1'b1;
    return e;
  endfunction

  // f = {N,Z,C}; table indexed by cond
  function automatic bit cond_take(input bit [2:0] cond, input bit [2:0] f);
    bit [7:0] tbl;
    tbl = {1'b0, 1'b0, !f[0], f[0], f[2], !f[1], f[1], 1'b1};
    return tbl[cond];
  endfunction

  always @(posedge clk) begin
    exp_t dec, ex, fin;
    bit [3:0] opc;
    if (!reset_n) begin
      sched.delete();
      m_flags  = '0;
      m_halted = 1'b0;
      cur      = idle_rec();
      chk_en   = 1'b1;
    end else if (chk_en) begin
      if (cur.latch) m_flags = {N, Z, C};
      if (cur.clr)   m_flags = '0;
      if (cur.ready && Instr_Valid) begin
        opc = Instr[15:12];
        dec = '{default: 0};
        fin = '{default: 0};
        fin.done = 1'b1;
        if (!cond_take(Instr[2:0], m_flags)) begin
          sched.push_back(dec);
          sched.push_back(fin);
        end else if (opc == 4'hF) begin
          fin.halted = 1'b1;
          sched.push_back(dec);
          sched.push_back(fin);
          m_halted = 1'b1;
        end else if (opc == 4'hE) begin
          dec.clr = 1'b1;
          sched.push_back(dec);
          sched.push_back(fin);
        end else begin
          ex = '{default: 0};
          ex.alu_op = (opc == 4'hD) ? 4'h5 : opc;
          ex.w      = Instr[11:9];
          ex.r      = Instr[8:6];
          ex.s      = Instr[5:3];
          ex.w_en   = (opc != 4'hD);
          ex.latch  = 1'b1;
          sched.push_back(dec);
          sched.push_back(ex);
          sched.push_back(fin);
        end
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = m_halted ? halt_rec() : idle_rec();
    end
  end

  // Single compare process, every cycle once the first reset edge has been seen
  always @(negedge clk) begin
    if (chk_en) begin
      check("Instr_Ready", Instr_Ready, cur.ready);
      check("Alu_Op", Alu_Op, cur.alu_op);
      check("R_Adr", R_Adr, cur.r);
      check("S_Adr", S_Adr, cur.s);
      check("W_Adr", W_Adr, cur.w);
      check("W_En", W_En, cur.w_en);
      check("Done", Done, cur.done);
      check("Halted", Halted, cur.halted);
      check("flags_NZC", {N_Q, Z_Q, C_Q}, m_flags);
    end
  end

  // ---------------- directed stimulus ----------------
  // Issue one word; returns cycles from accept to Done, plus W_En/Alu_Op seen on the way
  task automatic issue(input bit [15:0] ins, input bit [2:0] nzc,
                       output int lat, output bit wen_seen, output bit [3:0] op_seen);
    int k;
    lat      = -1;
    wen_seen = 1'b0;
    op_seen  = '0;
    @(negedge clk);
    Instr       = ins;
    Instr_Valid = 1'b1;
    {N, Z, C}   = nzc;
    k = 0;
    while (!Instr_Ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      check("accept_timeout", 0, 1);
      Instr_Valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    Instr_Valid = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      if (W_En) wen_seen = 1'b1;
      op_seen |= Alu_Op;
      if (Done) begin
        lat = t;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    bit wen;
    bit [3:0] op;
    int acc[$];
    int rdy_cnt, done_cnt;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("reset_ready", Instr_Ready, 1);
    check("reset_halted", Halted, 0);
    check("reset_flags", {N_Q, Z_Q, C_Q}, 0);

    // ADD W=1 R=2 S=3, ALU returns C
    issue(16'h4298, 3'b001, lat, wen, op);
    check("add_latency", lat, 3);
    check("add_wen", wen, 1);
    check("add_op", op, 4);
    check("add_cq", C_Q, 1);

    // CMP R=3 S=1, ALU returns Z
    issue(16'hD0C8, 3'b010, lat, wen, op);
    check("cmp_latency", lat, 3);
    check("cmp_wen", wen, 0);
    check("cmp_op", op, 5);
    check("cmp_flags", {N_Q, Z_Q, C_Q}, 3'b010);

    // cond=Z taken (ALU keeps Z so flags stay 010)
    issue(16'h4299, 3'b010, lat, wen, op);
    check("condz_latency", lat, 3);
    check("condz_wen", wen, 1);

    // cond=!Z skipped
    issue(16'h429A, 3'b000, lat, wen, op);
    check("condnz_latency", lat, 2);
    check("condnz_wen", wen, 0);
    check("condnz_flags", {N_Q, Z_Q, C_Q}, 3'b010);

    // Flags to 111 then CLRF
    issue(16'h4298, 3'b111, lat, wen, op);
    check("set111_flags", {N_Q, Z_Q, C_Q}, 3'b111);
    issue(16'hE000, 3'b000, lat, wen, op);
    check("clrf_latency", lat, 2);
    check("clrf_op", op, 0);
    check("clrf_wen", wen, 0);
    check("clrf_flags", {N_Q, Z_Q, C_Q}, 3'b000);

    // cond=110 never: ordinary op and HALT both skipped
    issue(16'h4298, 3'b101, lat, wen, op);
    issue(16'h4296, 3'b010, lat, wen, op);
    check("never_latency", lat, 2);
    check("never_flags", {N_Q, Z_Q, C_Q}, 3'b101);
    issue(16'hF006, 3'b000, lat, wen, op);
    check("never_halt_latency", lat, 2);
    check("never_halt_halted", Halted, 0);

    // HALT
    issue(16'hF000, 3'b000, lat, wen, op);
    check("halt_latency", lat, 2);
    check("halt_halted", Halted, 1);
    check("halt_ready", Instr_Ready, 0);
    Instr       = 16'h4298;
    Instr_Valid = 1'b1;
    rdy_cnt  = 0;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      rdy_cnt  += int'(Instr_Ready);
      done_cnt += int'(Done);
    end
    check("halt_ready_cnt", rdy_cnt, 0);
    check("halt_done_cnt", done_cnt, 0);
    check("halt_still", Halted, 1);
    Instr_Valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("unhalt_ready", Instr_Ready, 1);
    check("unhalt_halted", Halted, 0);
    check("unhalt_flags", {N_Q, Z_Q, C_Q}, 0);

    // Reset during EXEC of an ADD
    issue(16'h4298, 3'b111, lat, wen, op);
    @(negedge clk);
    Instr       = 16'h4298;
    Instr_Valid = 1'b1;
    {N, Z, C}   = 3'b110;
    @(posedge clk);
    @(negedge clk);
    Instr_Valid = 1'b0;
    @(negedge clk);
    check("rst_exec_wen_before", W_En, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_exec_wen_after", W_En, 0);
    check("rst_exec_done", Done, 0);
    check("rst_exec_flags", {N_Q, Z_Q, C_Q}, 0);
    check("rst_exec_ready", Instr_Ready, 1);
    repeat (2) @(negedge clk);

    // Valid held high: accepts only every 4 cycles
    Instr       = 16'h4298;
    Instr_Valid = 1'b1;
    {N, Z, C}   = 3'b000;
    for (int i = 0; i < 12; i++) begin
      if (Instr_Ready) acc.push_back(i);
      @(negedge clk);
    end
    Instr_Valid = 1'b0;
    check("b2b_accepts", acc.size(), 3);
    for (int i = 1; i < acc.size(); i++) check("b2b_gap", acc[i] - acc[i-1], 4);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer for the 16-bit integer datapath; the issuing end of the ALU interface.
- Accepts instruction words over a valid/ready handshake and decodes each into the 4-bit ALU op and register-file read/write selects.
- Reads back the ALU's combinational N/Z/C outputs and latches them into a status register.
- Supports condition-gated execution on the latched flags, a compare op, a flag-clear op, and HALT.

Parameters:
- ADR_W, 3, register-file address width; fixed by the instruction format, and any other value is a configuration error.
- COND_EN, 1, 1 = evaluate the cond field; 0 = treat every cond as "always".

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- Instr  in  16  instruction word.
- Instr_Valid  in  1  Instr is valid.
- Instr_Ready  out  1  sequencer can accept an instruction.
- Alu_Op  out  4  ALU operation select.
- R_Adr  out  ADR_W  register-file read port for the ALU R operand.
- S_Adr  out  ADR_W  register-file read port for the ALU S operand.
- W_Adr  out  ADR_W  register-file write address.
- W_En  out  1  register-file write enable, one-cycle pulse.
- N, Z, C  in  1 each  ALU combinational status.
- N_Q, Z_Q, C_Q  out  1 each  latched status flags.
- Done  out  1  one-cycle pulse when an instruction retires, whether executed or skipped.
- Halted  out  1  HALT has retired.

Behaviour:
- Instruction format: [15:12] opc, [11:9] W, [8:6] R, [5:3] S, [2:0] cond.
- opc 0000-1100: ALU op, Alu_Op = opc, result written to W.
- opc 1101 (CMP): Alu_Op = 0101 (subtract), flags updated, no write.
- opc 1110 (CLRF): flags cleared to 0, no ALU op, no write.
- opc 1111 (HALT): no ALU op, no write; enters HALT.
- cond encodings:
  - 000: always
  - 001: Z_Q
  - 010: !Z_Q
  - 011: N_Q
  - 100: C_Q
  - 101: !C_Q
  - 110, 111: never (NOP)
- States: IDLE, DECODE, EXEC, RETIRE, HALT.
- IDLE:
  - Instr_Ready = 1; all other control outputs are 0.
  - When Instr_Valid & Instr_Ready: latch Instr, go to DECODE.
  - Instr is sampled only on that edge.
- DECODE:
  - Evaluate cond against N_Q/Z_Q/C_Q as they stand at this cycle.
  - Cond false: go to RETIRE; flags and register file untouched.
  - Cond true and opc = 1111: go to HALT, and Done pulses in the first HALT cycle.
  - Cond true and opc = 1110: clear N_Q/Z_Q/C_Q at the DECODE exit edge, go to RETIRE.
  - Otherwise: go to EXEC.
- EXEC (exactly one cycle):
  - Alu_Op, R_Adr, S_Adr driven from the latched instruction.
  - W_Adr = W; W_En = 1 except for CMP.
  - On the exit edge: {N_Q, Z_Q, C_Q} <= {N, Z, C}; go to RETIRE.
- RETIRE: Done = 1 for one cycle, then IDLE.
- Outside EXEC: Alu_Op = 0000, R_Adr = S_Adr = W_Adr = 0, W_En = 0.
- Latency:
  - Executed ALU op: accept edge to Done = 3 cycles; Instr_Ready high again on the 4th cycle.
  - Skipped instruction or CLRF: 2 cycles.
- Throughput: at most one instruction per 4 cycles; no pipelining or overlap.
- Dependence: an instruction's cond sees the flags written by the previous instruction, because the flag latch completes before IDLE.
- HALT:
  - Instr_Ready = 0 and Halted = 1 persistently.
  - Instr_Valid is ignored; only reset exits.
- Reset values: state IDLE; Instr_Ready = 1; N_Q = Z_Q = C_Q = 0; Done = W_En = Halted = 0; Alu_Op and address outputs 0.
- Reset mid-operation: any state goes to IDLE on the next edge.
  - No W_En pulse is issued in the reset cycle; reset overrides EXEC outputs, which are registered.
  - In-flight instruction is discarded; no Done.
- Instr_Valid held high across a busy period: the next word is taken only on the cycle Instr_Ready = 1.
- All control outputs are registered (driven from state and the latched instruction); no combinational path from Instr to Alu_Op.

Decomposition:
- Shared package holds:
  - opcode constants (ALU_PASS_S through ALU_NEG, OP_CMP, OP_CLRF, OP_HALT)
  - cond encodings
  - state encoding
  - instruction field bit positions
- One natural sub-module: alu_cond_eval, a combinational cond + flags -> take function, reusable by a future branch unit.

Test Plan:
- Reset, then Instr = 0x4298 (ADD W=1, R=2, S=3, cond=always), ALU returns N=0, Z=0, C=1:
  - Alu_Op = 0100, R_Adr = 2, S_Adr = 3, W_Adr = 1, W_En = 1 in EXEC only.
  - Done 3 cycles after accept; C_Q = 1 afterwards.
- CMP 0xD0C8 (R=3, S=1), ALU returns Z=1:
  - W_En stays 0; Alu_Op = 0101; Z_Q = 1.
  - Next instr with cond 001 executes; same instr with cond 010 retires in 2 cycles with no W_En.
- CLRF 0xE000 after flags = 111 -> N_Q = Z_Q = C_Q = 0; Done 2 cycles after accept; Alu_Op stays 0000.
- cond = 110 on any opc, including HALT -> skipped, Done pulse, flags unchanged, Halted stays 0.
- HALT 0xF000 -> Done one pulse, Halted = 1, Instr_Ready = 0; further Valid ignored for 20 cycles; reset_n low one edge -> IDLE, Instr_Ready = 1, Halted = 0.
- reset_n low during EXEC of an ADD -> W_En 0 after the reset edge, no Done, flags 000; back-to-back Valid held high -> accepts only every 4 cycles.
